// File: rtl/game_screen_loader_pkg.sv
// Shared constants for the loading-bar screen: RGB565 colours, 96x64 screen
// size, bar outline/interior and glyph-strip coordinates, FSM state encoding.
package game_screen_loader_pkg;

    localparam logic [15:0] COL_BLACK = 16'h0000;
    localparam logic [15:0] COL_WHITE = 16'hFFFF;
    localparam logic [15:0] COL_GREEN = 16'h07E0;

    localparam int unsigned SCREEN_W = 96;
    localparam int unsigned SCREEN_H = 64;

    // Outline: left/right side posts
    localparam int unsigned OUT_L_X0    = 10;
    localparam int unsigned OUT_L_X1    = 12;
    localparam int unsigned OUT_R_X0    = 87;
    localparam int unsigned OUT_R_X1    = 89;
    localparam int unsigned OUT_SIDE_Y0 = 29;
    localparam int unsigned OUT_SIDE_Y1 = 46;
    // Outline: top/bottom rails
    localparam int unsigned OUT_TB_X0   = 13;
    localparam int unsigned OUT_TB_X1   = 86;
    localparam int unsigned OUT_TOP_Y0  = 26;
    localparam int unsigned OUT_TOP_Y1  = 28;
    localparam int unsigned OUT_BOT_Y0  = 47;
    localparam int unsigned OUT_BOT_Y1  = 49;

    // Bar interior
    localparam int unsigned BAR_IN_X0 = 14;
    localparam int unsigned BAR_IN_X1 = 85;
    localparam int unsigned BAR_IN_Y0 = 30;
    localparam int unsigned BAR_IN_Y1 = 45;
    localparam int unsigned BAR_IN_W  = BAR_IN_X1 - BAR_IN_X0 + 1;

    // "REPLAY?" banner strip
    localparam int unsigned GLYPH_X0 = 10;
    localparam int unsigned GLYPH_X1 = 44;
    localparam int unsigned GLYPH_Y0 = 18;
    localparam int unsigned GLYPH_Y1 = 22;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Inclusive range test on pixel coordinates
    function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                      input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/game_screen_loader_step_tick.sv
// step_tick: segment step counter. Counts enabled cycles and raises tick
// (combinational) on the enabled cycle where the count is TICKS-1, wrapping to 0.
// Ports: clk, rst (async high), en (count enable), clr (force to 0), tick.
module step_tick #(
    parameter int unsigned TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == CW'(TICKS - 1));

    // Next count: clear wins, then wrap on tick, then increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_screen_loader.sv
// game_screen_loader: segmented loading bar for a 96x64 RGB565 OLED.
// Fills N_SEG segments one per TICKS_PER_SEG cycles, shows a "REPLAY?" banner
// when full, drains on replay_ack.
// Ports: clk, rst (async high); start, pause, replay_ack controls;
//        x/y pixel address in; oled_data pixel colour (1-cycle latency);
//        seg_lit lit-segment count; busy (FILL/DRAIN); done (pulse on FULL entry).
module game_screen_loader
    import game_screen_loader_pkg::*;
#(
    parameter int unsigned N_SEG         = 4,
    parameter int unsigned TICKS_PER_SEG = 1_562_500,
    parameter int unsigned SEG_GAP       = 1,
    parameter logic [15:0] FILL_COLOUR   = 16'h07E0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        replay_ack,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    output logic [15:0] oled_data,
    output logic [3:0]  seg_lit,
    output logic        busy,
    output logic        done
);

    localparam int unsigned SEG_W     = (BAR_IN_W - (N_SEG - 1) * SEG_GAP) / N_SEG;
    localparam int unsigned SEG_PITCH = SEG_W + SEG_GAP;

    state_e      state_q, state_d;
    logic [3:0]  seg_q, seg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] pix_q, pix_d;

    logic        tick;
    logic        cnt_en;
    logic        cnt_clr;

    int unsigned xu;
    int unsigned yu;

    step_tick #(
        .TICKS (TICKS_PER_SEG)
    ) u_step_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .tick (tick)
    );

    // FSM next state, segment count and status flags
    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        done_d  = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (start) begin
                    state_d = ST_FILL;
                    seg_d   = '0;
                end
            end
            ST_FILL: begin
                cnt_en = !pause;
                if (tick) begin
                    seg_d = seg_q + 4'd1;
                    if (seg_q == 4'(N_SEG - 1)) begin
                        state_d = ST_FULL;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_FULL: begin
                // Hold the counter at 0 so DRAIN starts a fresh step period
                cnt_clr = 1'b1;
                if (replay_ack) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_en = !pause;
                if (tick) begin
                    seg_d = seg_q - 4'd1;
                    if (seg_q == 4'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                seg_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_FILL) || (state_d == ST_DRAIN);
    end

    // Pixel colour from the current address and the registered state
    always_comb begin
        xu    = 32'(x);
        yu    = 32'(y);
        pix_d = COL_BLACK;
        if ((in_range(xu, OUT_L_X0, OUT_L_X1) || in_range(xu, OUT_R_X0, OUT_R_X1)) &&
            in_range(yu, OUT_SIDE_Y0, OUT_SIDE_Y1)) begin
            pix_d = COL_WHITE;
        end else if (in_range(xu, OUT_TB_X0, OUT_TB_X1) &&
                     (in_range(yu, OUT_TOP_Y0, OUT_TOP_Y1) ||
                      in_range(yu, OUT_BOT_Y0, OUT_BOT_Y1))) begin
            pix_d = COL_WHITE;
        end else if (in_range(xu, BAR_IN_X0, BAR_IN_X1) &&
                     in_range(yu, BAR_IN_Y0, BAR_IN_Y1)) begin
            // Gap and remainder columns match no segment and stay black
            for (int unsigned k = 0; k < N_SEG; k++) begin
                if (in_range(xu, BAR_IN_X0 + k * SEG_PITCH,
                             BAR_IN_X0 + k * SEG_PITCH + SEG_W - 1) &&
                    (k < {28'd0, seg_q})) begin
                    pix_d = FILL_COLOUR;
                end
            end
        end else if ((state_q == ST_FULL) &&
                     in_range(xu, GLYPH_X0, GLYPH_X1) &&
                     in_range(yu, GLYPH_Y0, GLYPH_Y1)) begin
            // Banner strip rendered as a solid white band
            pix_d = COL_WHITE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            seg_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pix_q   <= COL_BLACK;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pix_q   <= pix_d;
        end
    end

    assign oled_data = pix_q;
    assign seg_lit   = seg_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_game_screen_loader.sv
// Bench for game_screen_loader: two instances (N_SEG=4 and N_SEG=3, both with
// 4 cycles per segment) share stimulus and are checked every cycle against an
// arithmetic reference model of the bar and its pixel geometry.
module tb_game_screen_loader;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pause;
    logic        replay_ack;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [15:0] oled_a, oled_b;
    logic [3:0]  seg_a, seg_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model, index 0 = N_SEG 4, index 1 = N_SEG 3
    // mode: 0 idle, 1 fill, 2 full, 3 drain
    int          n_seg [2] = '{4, 3};
    int          m_mode[2];
    int          m_act [2];
    int          m_seg [2];
    bit          m_done[2];
    logic [15:0] e_pix [2];

    always #5 clk = ~clk;

    game_screen_loader #(
        .N_SEG(4), .TICKS_PER_SEG(T), .SEG_GAP(1), .FILL_COLOUR(16'h07E0)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .replay_ack(replay_ack),
        .x(x), .y(y), .oled_data(oled_a), .seg_lit(seg_a), .busy(busy_a), .done(done_a)
    );

    game_screen_loader #(
        .N_SEG(3), .TICKS_PER_SEG(T), .SEG_GAP(1), .FILL_COLOUR(16'h07E0)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .replay_ack(replay_ack),
        .x(x), .y(y), .oled_data(oled_b), .seg_lit(seg_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic [15:0] ref_pix(input int n, input int seg, input bit full,
                                            input int px, input int py);
        int segw, pitch, off;
        segw  = (72 - (n - 1)) / n;
        pitch = segw + 1;
        if (((px >= 10 && px <= 12) || (px >= 87 && px <= 89)) && py >= 29 && py <= 46)
            return 16'hFFFF;
        if (px >= 13 && px <= 86 && ((py >= 26 && py <= 28) || (py >= 47 && py <= 49)))
            return 16'hFFFF;
        if (px >= 14 && px <= 85 && py >= 30 && py <= 45) begin
            off = px - 14;
            if ((off % pitch) < segw && (off / pitch) < n && (off / pitch) < seg)
                return 16'h07E0;
            return 16'h0000;
        end
        if (full && px >= 10 && px <= 44 && py >= 18 && py <= 22)
            return 16'hFFFF;
        return 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_act[i]  = 0;
            m_seg[i]  = 0;
            m_done[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        if (rst) begin
            m_mode[i] = 0; m_act[i] = 0; m_seg[i] = 0; m_done[i] = 1'b0;
            return;
        end
        m_done[i] = 1'b0;
        case (m_mode[i])
            0: if (start) begin m_mode[i] = 1; m_act[i] = 0; m_seg[i] = 0; end
            1: if (!pause) begin
                m_act[i]++;
                m_seg[i] = m_act[i] / T;
                if (m_seg[i] == n_seg[i]) begin m_mode[i] = 2; m_done[i] = 1'b1; end
            end
            2: if (replay_ack) begin m_mode[i] = 3; m_act[i] = 0; end
            default: if (!pause) begin
                m_act[i]++;
                m_seg[i] = n_seg[i] - m_act[i] / T;
                if (m_seg[i] == 0) m_mode[i] = 0;
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("seg_lit_n4", 32'(seg_a), 32'(m_seg[0]));
        chk("busy_n4",    32'(busy_a), 32'(m_mode[0] == 1 || m_mode[0] == 3));
        chk("done_n4",    32'(done_a), 32'(m_done[0]));
        chk("pixel_n4",   32'(oled_a), 32'(e_pix[0]));
        chk("seg_lit_n3", 32'(seg_b), 32'(m_seg[1]));
        chk("busy_n3",    32'(busy_b), 32'(m_mode[1] == 1 || m_mode[1] == 3));
        chk("done_n3",    32'(done_b), 32'(m_done[1]));
        chk("pixel_n3",   32'(oled_b), 32'(e_pix[1]));
    endtask

    // One clock: predict pixel from pre-edge state, step model, compare after edge
    task automatic cyc();
        for (int i = 0; i < 2; i++)
            e_pix[i] = rst ? 16'h0000
                           : ref_pix(n_seg[i], m_seg[i], m_mode[i] == 2, int'(x), int'(y));
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        check_outputs();
    endtask

    task automatic rand_xy();
        x = 7'($urandom_range(0, 95));
        y = 6'($urandom_range(0, 63));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_seg"},  32'({seg_a, seg_b}), 32'(0));
        chk({tag, "_busy"}, 32'({busy_a, busy_b}), 32'(0));
        chk({tag, "_done"}, 32'({done_a, done_b}), 32'(0));
        chk({tag, "_pix"},  32'({oled_a, oled_b}), 32'(0));
    endtask

    initial begin
        int done_at;
        int any_done;
        logic [3:0] snap;

        rst = 1'b0; start = 1'b0; pause = 1'b0; replay_ack = 1'b0; x = '0; y = '0;
        model_reset();
        #1 rst = 1'b1;
        #1 check_zero("reset_initial");
        repeat (2) cyc();
        rst = 1'b0;

        // Plain fill; stray replay_ack and start during FILL are ignored
        start = 1'b1; rand_xy(); cyc(); start = 1'b0;
        done_at = -1;
        for (int i = 1; i <= 40 && done_at < 0; i++) begin
            rand_xy();
            replay_ack = (i == 3);
            start      = (i == 5);
            cyc();
            if (done_a) done_at = i;
        end
        replay_ack = 1'b0; start = 1'b0;
        chk("fill_done_latency", 32'(done_at), 32'(16));
        rand_xy(); cyc();
        chk("done_one_cycle", 32'(done_a), 32'(0));

        // Drain both bars; a start during DRAIN is ignored, no done pulse
        replay_ack = 1'b1; rand_xy(); cyc(); replay_ack = 1'b0;
        any_done = 0;
        for (int i = 1; i <= 40 && (busy_a || busy_b); i++) begin
            rand_xy();
            start = (i == 6);
            cyc();
            if (done_a || done_b) any_done = 1;
        end
        start = 1'b0;
        chk("drain_no_done", 32'(any_done), 32'(0));
        chk("drain_idle", 32'({busy_a, seg_a}), 32'(0));

        // Fill with a 10-cycle pause: done slips by exactly 10
        start = 1'b1; rand_xy(); cyc(); start = 1'b0;
        done_at = -1;
        snap = '0;
        for (int i = 1; i <= 60 && done_at < 0; i++) begin
            rand_xy();
            pause = (i >= 6 && i < 16);
            cyc();
            if (i == 5) snap = seg_a;
            if (i >= 6 && i < 16) chk("pause_hold", 32'(seg_a), 32'(snap));
            if (done_a) done_at = i;
        end
        pause = 1'b0;
        chk("pause_done_latency", 32'(done_at), 32'(26));
        replay_ack = 1'b1; cyc(); replay_ack = 1'b0;
        for (int i = 0; i < 60 && (busy_a || busy_b); i++) begin rand_xy(); cyc(); end

        // Random control traffic
        for (int i = 0; i < 3000; i++) begin
            start      = ($urandom_range(0, 7) == 0);
            pause      = ($urandom_range(0, 3) == 0);
            replay_ack = ($urandom_range(0, 7) == 0);
            rand_xy();
            cyc();
        end
        start = 1'b0; pause = 1'b0; replay_ack = 1'b0;

        // Full-screen sweep with two segments lit, paused in FILL
        rst = 1'b1; cyc(); rst = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (8) cyc();
        chk("sweep_seg2", 32'({seg_a, seg_b}), 32'({4'd2, 4'd2}));
        pause = 1'b1;
        for (int yy = 0; yy < 64; yy++)
            for (int xx = 0; xx < 96; xx++) begin
                x = 7'(xx); y = 6'(yy); cyc();
            end

        // Full-screen sweep in FULL, banner shown
        pause = 1'b0;
        repeat (18) cyc();
        for (int yy = 0; yy < 64; yy++)
            for (int xx = 0; xx < 96; xx++) begin
                x = 7'(xx); y = 6'(yy); cyc();
            end

        // Asynchronous reset mid-FILL, then restart from zero
        rst = 1'b1; cyc(); rst = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        x = 7'd20; y = 6'd35;
        repeat (8) cyc();
        #2 rst = 1'b1;
        model_reset();
        #1 check_zero("reset_async");
        cyc();
        rst = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        chk("restart_seg0", 32'(seg_a), 32'(0));
        repeat (6) cyc();
        chk("restart_seg1", 32'(seg_a), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
